// File: rtl/iterative_alu_if.sv
// Request/result handshake bundle between an issuing stage and iterative_alu.
// master drives requests and accepts results; slave is the execute unit.
interface iterative_alu_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_control, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/iterative_alu.sv
// Multi-cycle execute unit: single-cycle logic/arith ops, serial shifter, held result.
// Define ITER_ALU_FAST_SHIFT_EN to replace the serial shifter with a one-cycle barrel shifter.
module iterative_alu #(
  parameter int unsigned XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  iterative_alu_if.slave bus
);
  localparam int unsigned ShW = $clog2(XLEN);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpSlt  = 4'b1000;
  localparam logic [3:0] OpSltu = 4'b1001;

`ifdef ITER_ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {StIdle, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [ShW-1:0]  shamt;
  logic [XLEN-1:0] quick_res;
  logic            quick_illegal;

  assign shamt = bus.op_b[ShW-1:0];

  // Result for every op that finishes on the accept edge.
  always_comb begin
    quick_res     = '0;
    quick_illegal = 1'b0;
    case (bus.alu_control)
      OpAnd:  quick_res = bus.op_a & bus.op_b;
      OpOr:   quick_res = bus.op_a | bus.op_b;
      OpAdd:  quick_res = bus.op_a + bus.op_b;
      OpXor:  quick_res = bus.op_a ^ bus.op_b;
      OpSub:  quick_res = bus.op_a - bus.op_b;
      OpSlt:  quick_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
      OpSltu: quick_res = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
`ifdef ITER_ALU_FAST_SHIFT_EN
      OpSll:  quick_res = bus.op_a << shamt;
      OpSrl:  quick_res = bus.op_a >> shamt;
      OpSra:  quick_res = $unsigned($signed(bus.op_a) >>> shamt);
`else
      // Serial build only reaches here for shamt == 0.
      OpSll, OpSrl, OpSra: quick_res = bus.op_a;
`endif
      default: quick_illegal = 1'b1;
    endcase
  end

`ifndef ITER_ALU_FAST_SHIFT_EN
  logic [3:0]     op_q, op_d;
  logic [ShW-1:0] cnt_q, cnt_d;
  logic           is_shift;

  assign is_shift = (bus.alu_control == OpSll) || (bus.alu_control == OpSrl) ||
                    (bus.alu_control == OpSra);
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifndef ITER_ALU_FAST_SHIFT_EN
    op_d      = op_q;
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          illegal_d = quick_illegal;
          result_d  = quick_res;
          state_d   = StDone;
`ifndef ITER_ALU_FAST_SHIFT_EN
          op_d = bus.alu_control;
          if (is_shift && (shamt != '0)) begin
            result_d = bus.op_a;
            cnt_d    = shamt;
            state_d  = StShift;
          end
`endif
        end
      end
`ifndef ITER_ALU_FAST_SHIFT_EN
      StShift: begin
        case (op_q)
          OpSll:   result_d = {result_q[XLEN-2:0], 1'b0};
          OpSra:   result_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
          default: result_d = {1'b0, result_q[XLEN-1:1]};
        endcase
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == ShW'(1)) state_d = StDone;
      end
`endif
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    zero_d      = (result_d == '0);
    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifndef ITER_ALU_FAST_SHIFT_EN
      op_q        <= OpAnd;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifndef ITER_ALU_FAST_SHIFT_EN
      op_q        <= op_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_iterative_alu.sv
// Directed self-checking bench for iterative_alu (XLEN = 32).
module tb_iterative_alu;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  iterative_alu_if #(.XLEN(32)) bus ();

  iterative_alu #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, measure cycles to out_valid, capture outputs, then take the result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic z,
                        output logic ill);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_before_issue: got %b expected 1", bus.in_ready);
    end
    bus.alu_control = op;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.in_valid    = 1'b1;
    cyc();
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'hx;
    bus.op_a        = 32'hx;
    bus.op_b        = 32'hx;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      cyc();
      lat++;
    end
    res = bus.result;
    z   = bus.zero;
    ill = bus.illegal;
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp += 5;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    if (bus.result !== 32'h0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result);
    end
    if (bus.zero !== 1'b1) begin
      n_fail++; $display("FAIL reset_zero: got %b expected 1", bus.zero);
    end
    if (bus.illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_illegal: got %b expected 0", bus.illegal);
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [10] = '{4'b0010, 4'b0110, 4'b0010, 4'b0000, 4'b0001,
                              4'b0011, 4'b1000, 4'b1001, 4'b1000, 4'b0110};
    logic [31:0] va  [10] = '{32'd5, 32'd3, 32'hFFFF_FFFF, 32'hF0F0, 32'hF0F0,
                              32'hF0F0, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] vb  [10] = '{32'd7, 32'd3, 32'd1, 32'hFF00, 32'hFF00,
                              32'hFF00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1};
    logic [31:0] exp [10] = '{32'd12, 32'd0, 32'd0, 32'hF000, 32'hFFF0,
                              32'h0FF0, 32'd0, 32'd1, 32'd1, 32'hFFFF_FFFF};
    int lat;
    logic [31:0] res;
    logic z, ill;
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], va[i], vb[i], lat, res, z, ill);
      n_cmp += 4;
      if (res !== exp[i]) begin
        n_fail++; $display("FAIL alu_result[%0d]: got %h expected %h", i, res, exp[i]);
      end
      if (z !== (exp[i] == 32'h0)) begin
        n_fail++; $display("FAIL alu_zero[%0d]: got %b expected %b", i, z, exp[i] == 32'h0);
      end
      if (lat != 1) begin
        n_fail++; $display("FAIL alu_latency[%0d]: got %0d expected 1", i, lat);
      end
      if (ill !== 1'b0) begin
        n_fail++; $display("FAIL alu_illegal[%0d]: got %b expected 0", i, ill);
      end
    end
  endtask

  task automatic test_shifts();
    logic [3:0]  ops [7] = '{4'b0111, 4'b0101, 4'b0100, 4'b0111, 4'b0101, 4'b0100, 4'b0111};
    logic [31:0] va  [7] = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'h8000_0000,
                             32'h1234_5678, 32'hFF, 32'h7FFF_FFF0};
    logic [31:0] vb  [7] = '{32'd4, 32'd4, 32'd31, 32'd32, 32'd8, 32'd36, 32'd4};
    logic [31:0] exp [7] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h8000_0000,
                             32'h0012_3456, 32'hFF0, 32'h07FF_FFFF};
    int          sh  [7] = '{4, 4, 31, 0, 8, 4, 4};
    int lat, exp_lat;
    logic [31:0] res;
    logic z, ill;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], va[i], vb[i], lat, res, z, ill);
`ifdef ITER_ALU_FAST_SHIFT_EN
      exp_lat = 1;
`else
      exp_lat = sh[i] + 1;
`endif
      n_cmp += 3;
      if (res !== exp[i]) begin
        n_fail++; $display("FAIL shift_result[%0d]: got %h expected %h", i, res, exp[i]);
      end
      if (z !== 1'b0) begin
        n_fail++; $display("FAIL shift_zero[%0d]: got %b expected 0", i, z);
      end
      if (lat != exp_lat) begin
        n_fail++; $display("FAIL shift_latency[%0d]: got %0d expected %0d", i, lat, exp_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int wait_cyc;
    bus.alu_control = 4'b0010;
    bus.op_a        = 32'd10;
    bus.op_b        = 32'd20;
    bus.in_valid    = 1'b1;
    cyc();
    bus.in_valid    = 1'b0;
    wait_cyc = 0;
    while (bus.out_valid !== 1'b1 && wait_cyc < 64) begin
      cyc();
      wait_cyc++;
    end
    // Three stalled cycles in DONE, then take the result while offering a new request.
    for (int i = 0; i < 3; i++) begin
      n_cmp += 4;
      if (bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, bus.out_valid);
      end
      if (bus.result !== 32'd30) begin
        n_fail++; $display("FAIL bp_result[%0d]: got %h expected 1e", i, bus.result);
      end
      if (bus.zero !== 1'b0) begin
        n_fail++; $display("FAIL bp_zero[%0d]: got %b expected 0", i, bus.zero);
      end
      if (bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
      end
      cyc();
    end
    bus.out_ready   = 1'b1;
    bus.alu_control = 4'b0011;
    bus.op_a        = 32'hAAAA_0000;
    bus.op_b        = 32'h0000_5555;
    bus.in_valid    = 1'b1;
    n_cmp += 2;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready_at_take: got %b expected 0", bus.in_ready);
    end
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_out_valid_at_take: got %b expected 1", bus.out_valid);
    end
    cyc();
    bus.out_ready = 1'b0;
    n_cmp += 2;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_out_valid_after_take: got %b expected 0", bus.out_valid);
    end
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_in_ready_after_take: got %b expected 1", bus.in_ready);
    end
    cyc();
    bus.in_valid = 1'b0;
    n_cmp += 2;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_next_out_valid: got %b expected 1", bus.out_valid);
    end
    if (bus.result !== 32'hAAAA_5555) begin
      n_fail++; $display("FAIL bp_next_result: got %h expected aaaa5555", bus.result);
    end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    int lat;
    logic [31:0] res;
    logic z, ill;
    run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, lat, res, z, ill);
    n_cmp += 4;
    if (ill !== 1'b1) begin
      n_fail++; $display("FAIL illegal_flag: got %b expected 1", ill);
    end
    if (res !== 32'h0) begin
      n_fail++; $display("FAIL illegal_result: got %h expected 0", res);
    end
    if (z !== 1'b1) begin
      n_fail++; $display("FAIL illegal_zero: got %b expected 1", z);
    end
    if (lat != 1) begin
      n_fail++; $display("FAIL illegal_latency: got %0d expected 1", lat);
    end
    n_cmp++;
    if (bus.illegal !== 1'b1) begin
      n_fail++; $display("FAIL illegal_held_idle: got %b expected 1", bus.illegal);
    end
    run_op(4'b0010, 32'd2, 32'd2, lat, res, z, ill);
    n_cmp += 2;
    if (ill !== 1'b0) begin
      n_fail++; $display("FAIL illegal_cleared: got %b expected 0", ill);
    end
    if (res !== 32'd4) begin
      n_fail++; $display("FAIL illegal_next_add: got %h expected 4", res);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    logic [31:0] res;
    logic z, ill;
    bus.alu_control = 4'b0100;
    bus.op_a        = 32'h1;
    bus.op_b        = 32'd31;
    bus.in_valid    = 1'b1;
    cyc();
    bus.in_valid    = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    #1;
    n_cmp += 3;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_out_valid: got %b expected 0", bus.out_valid);
    end
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_in_ready: got %b expected 1", bus.in_ready);
    end
    if (bus.result !== 32'h0) begin
      n_fail++; $display("FAIL abort_result: got %h expected 0", bus.result);
    end
    cyc();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bus.out_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_stale_result: got %0d valid cycles expected 0", seen);
    end
    run_op(4'b0010, 32'd1, 32'd1, lat, res, z, ill);
    n_cmp += 2;
    if (res !== 32'd2) begin
      n_fail++; $display("FAIL abort_next_add: got %h expected 2", res);
    end
    if (lat != 1) begin
      n_fail++; $display("FAIL abort_next_latency: got %0d expected 1", lat);
    end
  endtask

  initial begin
    n_cmp           = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.alu_control = 4'h0;
    bus.op_a        = 32'h0;
    bus.op_b        = 32'h0;
    #12;
    test_reset();
    cyc();
    rst = 1'b0;
    cyc();
    test_alu_ops();
    test_shifts();
    test_backpressure();
    test_illegal();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
